// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one word-wide UART transmitter among NUM_REQ requesters.
// Optional per-word abort timer is compiled in with `define TX_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int PTR_W       = 2,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [PTR_W-1:0]          grant_id,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t              state, state_n;
  logic [PTR_W-1:0]    ptr, ptr_n;
  logic [PTR_W-1:0]    grant_id_n;
  logic [PTR_W-1:0]    sel, idx;
  logic                found;
  logic [NUM_REQ-1:0]  ack_n;
  logic                tx_start_n, busy_n;
  logic [DATA_W-1:0]   tx_data_n;
  logic                done_q, done_rise;
  logic                expired;
  logic [DATA_W-1:0]   words [NUM_REQ];

  if (PTR_W != ((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1) || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: PTR_W must be clog2(NUM_REQ) and TIMEOUT_CYC positive");
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_W +: DATA_W];
  end

  // The transmitter's done is a level; only a fresh rising edge marks a finished word.
  assign done_rise = tx_done & ~done_q;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] busy_cnt;

  assign expired = (state == BUSY) && (busy_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Counter sits at zero outside BUSY, so it is already clear on entry to BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expired && !done_rise;
      busy_cnt    <= (state == BUSY) ? busy_cnt + 1'b1 : '0;
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_id_n = grant_id;
    tx_data_n  = tx_data;
    tx_start_n = tx_start;
    busy_n     = busy;
    ack_n      = '0;
    case (state)
      IDLE: begin
        if (found) begin
          tx_data_n  = words[sel];
          grant_id_n = sel;
          tx_start_n = 1'b1;
          busy_n     = 1'b1;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        if (done_rise || expired) begin
          ack_n      = NUM_REQ'(1) << grant_id;
          tx_start_n = 1'b0;
          busy_n     = 1'b0;
          ptr_n      = PTR_W'((int'(grant_id) + 1) % NUM_REQ);
          state_n    = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      ack      <= ack_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
      busy     <= busy_n;
      grant_id <= grant_id_n;
      done_q   <= tx_done;
    end
  end

endmodule
